// File: rtl/modrm_pkg.sv
// Shared types and helpers for the ModR/M operand fetcher and the decoder's
// instruction-length logic.
package modrm_pkg;

    // FSM state encoding; the numeric values are fixed so that state dumps
    // line up with the rest of the execution bank.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MODRM   = 3'd1,
        DISP_LO = 3'd2,
        DISP_HI = 3'd3,
        DONE    = 3'd4
    } state_t;

    // mod field value that selects a register operand (no memory access).
    localparam logic [1:0] MOD_REG   = 2'b11;

    // rm value that, with mod=00, means a bare 16-bit direct address.
    localparam logic [2:0] RM_DIRECT = 3'b110;

    // Number of displacement bytes that follow a ModR/M byte (0, 1 or 2).
    function automatic logic [1:0] disp_len(input logic [1:0] mod,
                                            input logic [2:0] rm);
        logic [1:0] n;
        unique case (mod)
            2'b00:   n = (rm == RM_DIRECT) ? 2'd2 : 2'd0;
            2'b01:   n = 2'd1;
            2'b10:   n = 2'd2;
            default: n = 2'd0; // MOD_REG: register operand
        endcase
        return n;
    endfunction

endpackage

// File: rtl/modrm_disp_len.sv
// Combinational mod/rm -> displacement-length decode. Kept as its own block
// so the instruction-length logic in the decoder can reuse the same decode.
module modrm_disp_len
    import modrm_pkg::*;
(
    input  logic [1:0] mod_i,
    input  logic [2:0] rm_i,
    output logic [1:0] len_o
);

    // Pure decode of the ModR/M addressing form into a byte count.
    assign len_o = disp_len(mod_i, rm_i);

endmodule

// File: rtl/modrm_operand_fetcher.sv
// ModR/M operand fetcher: pulls the ModR/M byte and up to two displacement
// bytes from the prefetch-queue stream and presents mod/reg/rm plus a
// sign-extended 16-bit displacement to the execution bank.
module modrm_operand_fetcher
    import modrm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [7:0]  in_byte_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [1:0]  mod_o,
    output logic [2:0]  reg_o,
    output logic [2:0]  rm_o,
    output logic [15:0] disp_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        busy_o
);

    state_t      state_q;
    logic [1:0]  mod_q;
    logic [2:0]  reg_q;
    logic [2:0]  rm_q;
    logic [15:0] disp_q;
    logic [1:0]  len_q;     // displacement bytes still owed by this operand
    logic [1:0]  byte_len;  // length decoded from the byte on the bus

    // Decode the incoming byte as if it were a ModR/M byte; only used in MODRM.
    modrm_disp_len u_disp_len (
        .mod_i (in_byte_i[7:6]),
        .rm_i  (in_byte_i[2:0]),
        .len_o (byte_len)
    );

    // Byte-accepting states take the stream; a flush blocks the transfer so
    // the queue does not lose a byte that belongs to the redirected stream.
    always_comb begin
        in_ready_o = 1'b0;
        if (!flush_i) begin
            in_ready_o = (state_q == MODRM) || (state_q == DISP_LO) ||
                         (state_q == DISP_HI);
        end
    end

    // Status outputs are a pure function of the state register.
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);

    assign mod_o  = mod_q;
    assign reg_o  = reg_q;
    assign rm_o   = rm_q;
    assign disp_o = disp_q;

    // Sequencer: walks ModR/M -> displacement bytes -> DONE, assembling the
    // displacement as bytes arrive; a flush abandons the operand at once.
    // NOTE: every register here uses <= so all updates see pre-edge values
    // regardless of statement order inside the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mod_q   <= 2'b00;
            reg_q   <= 3'b000;
            rm_q    <= 3'b000;
            disp_q  <= 16'h0000;
            len_q   <= 2'd0;
        end else if (flush_i) begin
            // mod/reg/rm are left as-is; they are meaningless until DONE.
            state_q <= IDLE;
            disp_q  <= 16'h0000;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= MODRM;
                        disp_q  <= 16'h0000;
                    end
                end
                MODRM: begin
                    if (in_valid_i) begin
                        mod_q   <= in_byte_i[7:6];
                        reg_q   <= in_byte_i[5:3];
                        rm_q    <= in_byte_i[2:0];
                        len_q   <= byte_len;
                        state_q <= (byte_len == 2'd0) ? DONE : DISP_LO;
                    end
                end
                DISP_LO: begin
                    if (in_valid_i) begin
                        disp_q[7:0] <= in_byte_i;
                        if (len_q == 2'd1) begin
                            disp_q[15:8] <= {8{in_byte_i[7]}};
                            state_q      <= DONE;
                        end else begin
                            state_q <= DISP_HI;
                        end
                    end
                end
                DISP_HI: begin
                    if (in_valid_i) begin
                        disp_q[15:8] <= in_byte_i;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately ignored here; no overlap.
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/modrm_operand_fetcher.md
# modrm_operand_fetcher

Sequential front end that feeds the register-bank addressing decoder of the 8088 execution bank. On a start request from the instruction decoder, it pulls the ModR/M byte and any 8- or 16-bit displacement bytes from the prefetch-queue byte stream. It splits the ModR/M byte into mod/reg/rm and presents them with a sign-extended 16-bit displacement on a valid/ready output. The block produces the `mod`/`RM` pair that the execution bank's addressing ROM consumes.

## Interface
- No parameters.
- `clk` input 1: single clock; everything is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: from the instruction decoder; the next queue byte is a ModR/M byte.
- `flush` input 1: synchronous abort on a queue flush (jump or interrupt).
- `in_byte` input 8: byte from the prefetch queue.
- `in_valid` input 1: `in_byte` is valid.
- `in_ready` output 1: this block accepts `in_byte` this cycle.
- `mod` output 2: ModR/M bits [7:6].
- `reg` output 3: ModR/M bits [5:3].
- `rm` output 3: ModR/M bits [2:0].
- `disp` output 16: displacement, sign-extended when 8-bit; 0 when there is none.
- `out_valid` output 1: the operand descriptor is complete.
- `out_ready` input 1: the execution bank consumes the descriptor.
- `busy` output 1: the state is not IDLE.

## Operation
- States: IDLE, MODRM, DISP_LO, DISP_HI, DONE.
- IDLE:
  - `in_ready`=0.
  - `start`=1 → MODRM; clear `disp` to 0.
- MODRM:
  - `in_ready`=1.
  - On handshake (`in_valid`&`in_ready`), latch `mod`/`reg`/`rm` from `in_byte` and compute the displacement length n.
- Displacement length n:
  - mod=00 and rm=110 → n=2 (direct address).
  - mod=00 otherwise → n=0.
  - mod=01 → n=1.
  - mod=10 → n=2.
  - mod=11 → n=0 (register operand).
- After MODRM: n=0 → DONE; n≥1 → DISP_LO.
- DISP_LO:
  - `in_ready`=1.
  - On handshake, `disp[7:0]`=`in_byte`.
  - n=1: `disp[15:8]`={8{`in_byte[7]`}} → DONE.
  - n=2: → DISP_HI.
- DISP_HI:
  - `in_ready`=1.
  - On handshake, `disp[15:8]`=`in_byte` → DONE.
- DONE:
  - `out_valid`=1; outputs are held stable.
  - `out_ready`=1 → IDLE.
- `start` outside IDLE is ignored.
- When `in_valid`=0 the state holds; stalls of any length are legal.
- `flush` overrides every other input:
  - Next state is IDLE; `disp` is cleared.
  - `mod`/`reg`/`rm` keep their value but are don't-care.
  - No byte is consumed that cycle: `in_ready` is forced to 0 while `flush`=1.
- `flush` together with `start` in IDLE → stay in IDLE.
- Reset mid-operation (`rst_n` low) → immediate return to IDLE.

## Timing
- Reset values:
  - `mod`=00, `reg`=000, `rm`=000, `disp`=0000.
  - `out_valid`=0, `busy`=0, `in_ready`=0.
- `in_ready` and `out_valid` are decoded from state only (Moore), except that `flush` gates `in_ready`.
- All data outputs are registered.
- Latency from the `start` cycle to `out_valid`, with `in_valid` held at 1:
  - n=0: 2 cycles.
  - n=1: 3 cycles.
  - n=2: 4 cycles.
- `out_valid` rises the cycle after the last byte handshake.
- The earliest next `start` is the cycle after the `out_ready` handshake; there is no back-to-back overlap.
- Handshake rule: a byte transfers on exactly the rising edge where `in_valid`&`in_ready`=1. The queue must hold `in_byte` until then.

## Structure
- Package `modrm_pkg`:
  - `state_t` enum: IDLE=0, MODRM=1, DISP_LO=2, DISP_HI=3, DONE=4.
  - `MOD_REG`=2'b11.
  - `RM_DIRECT`=3'b110.
  - Function `disp_len(mod, rm)` returning 2 bits.
- Sub-module `modrm_disp_len`: combinational mod/rm → n decode, shared with the decoder's instruction-length logic.
- The top module holds the FSM, the field registers and the displacement assembly.

## Test plan
- mod=11 register form:
  - Stimulus: `start`, then byte 0xC3.
  - Response: `mod`=11, `reg`=000, `rm`=011, `disp`=0000; `out_valid` 2 cycles after `start`.
- Direct address:
  - Stimulus: byte 0x06, then 0x34, 0x12.
  - Response: `mod`=00, `rm`=110, `disp`=0x1234; `out_valid` at cycle 4.
- 8-bit displacement, negative:
  - Stimulus: byte 0x47, then 0xF0.
  - Response: `mod`=01, `rm`=111, `disp`=0xFFF0.
  - Also 0x47, 0x10 → `disp`=0x0010.
- 16-bit displacement with stalls:
  - Stimulus: byte 0x80, then `in_valid` low for 3 cycles, then 0xCD, 0xAB.
  - Response: `disp`=0xABCD; no byte is consumed while `in_valid`=0.
- Flush mid-displacement:
  - Stimulus: 0x80, 0xCD, then `flush` in DISP_HI while `in_valid`=1.
  - Response: IDLE next cycle; `in_ready`=0 during flush; `out_valid` never asserted; `disp`=0.
- Output backpressure and ignored start:
  - Stimulus: hold `out_ready`=0 for 5 cycles in DONE while pulsing `start`.
  - Response: outputs stable, `start` ignored.
  - Asynchronous `rst_n` pulse mid-MODRM → all outputs at reset values immediately.
